// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg / branch_predictor
//
// Fetch-side branch predictor: a direct-mapped BTB where every entry holds a
// valid bit, a tag, a target address and a 2-bit saturating counter.
//
// The fetch PC is looked up and the result is registered into bpred_o one cycle
// later. That record travels down the pipe to the exe-stage prediction checker.
// Resolved branches reported by exe train the table.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   fetch_valid_i  fetch PC valid this cycle
//   stall_i        fetch stalled; bpred_o holds its value
//   pc_fetch_i     fetch PC; index = pc[IDX_W+1:2], tag = pc[IDX_W+2 +: TAG_W]
//   upd_valid_i    exe reports a resolved conditional branch or JALR
//   upd_pc_i       PC of the resolved instruction
//   upd_taken_i    resolved decision, 1 = taken
//   upd_target_i   resolved target address
//   bpred_o        prediction for the PC fetched in the previous cycle
//   ready_o        table initialised; predictions are meaningful
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int ADDR_W = 40;

  typedef logic [ADDR_W-1:0] addr_pc_t;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } decision_t;

  typedef struct packed {
    logic      is_branch;
    decision_t decision;
    addr_pc_t  pred_addr;
  } branch_pred_t;

endpackage

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fetch_valid_i,
  input  logic         stall_i,
  input  addr_pc_t     pc_fetch_i,
  input  logic         upd_valid_i,
  input  addr_pc_t     upd_pc_i,
  input  logic         upd_taken_i,
  input  addr_pc_t     upd_target_i,
  output branch_pred_t bpred_o,
  output logic         ready_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_cnt, idx_cnt_d;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  addr_pc_t           target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  // ---------------------------------------------------------------------------
  // Init FSM: walks every index once, clearing the valid bit, before going READY.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    idx_cnt_d = idx_cnt;
    case (state_q)
      INIT: begin
        idx_cnt_d = idx_cnt + 1'b1;
        if (idx_cnt == IDX_W'(ENTRIES - 1)) begin
          state_d   = READY;
          idx_cnt_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= INIT;
      idx_cnt <= '0;
    end else begin
      state_q <= state_d;
      idx_cnt <= idx_cnt_d;
    end
  end

  assign ready_o = (state_q == READY);

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  branch_pred_t     lookup;

  assign fetch_idx = pc_fetch_i[IDX_W+1:2];
  assign fetch_tag = pc_fetch_i[IDX_W+2 +: TAG_W];
  // Valid bits are stale until the init walk completes, so gate hits on READY.
  assign fetch_hit = (state_q == READY) && valid_q[fetch_idx] &&
                     (tag_mem[fetch_idx] == fetch_tag);

  always_comb begin
    lookup           = '0;
    lookup.is_branch = fetch_hit;
    lookup.decision  = (fetch_hit && ctr_mem[fetch_idx][1]) ? TAKEN : NOT_TAKEN;
    // A hit always forwards the stored target; decision tells the checker
    // whether the branch is expected to go there or fall through.
    lookup.pred_addr = fetch_hit ? target_mem[fetch_idx] : pc_fetch_i + addr_pc_t'(4);
  end

  // Tables are read with the pre-edge contents, so a lookup and an update to
  // the same index in one cycle return the old entry (no bypass).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bpred_o <= '0;
    end else if (!stall_i) begin
      bpred_o <= fetch_valid_i ? lookup : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_en;
  logic             upd_hit;
  logic             wr_ctr, wr_target, wr_alloc;
  logic [1:0]       ctr_new;

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+2 +: TAG_W];
  assign upd_en  = upd_valid_i && (state_q == READY) && !rst_i;
  assign upd_hit = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  always_comb begin
    wr_ctr    = 1'b0;
    wr_target = 1'b0;
    wr_alloc  = 1'b0;
    ctr_new   = ctr_mem[upd_idx];
    if (upd_en) begin
      if (upd_hit) begin
        wr_ctr = 1'b1;
        if (upd_taken_i) begin
          wr_target = 1'b1;
          if (ctr_mem[upd_idx] != 2'd3) ctr_new = ctr_mem[upd_idx] + 2'd1;
        end else if (ctr_mem[upd_idx] != 2'd0) begin
          ctr_new = ctr_mem[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        // Allocate (evicting whatever lived at this index) as weakly taken.
        wr_alloc  = 1'b1;
        wr_ctr    = 1'b1;
        wr_target = 1'b1;
        ctr_new   = 2'd2;
      end
    end
  end

  // Valid bits are cleared by the init walk rather than by rst_i directly, so
  // reset stays a single-cycle event and the walk covers every index.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      valid_q[idx_cnt] <= 1'b0;
    end else if (wr_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // NOTE: the tag/target/counter arrays are deliberately not reset; they are
  // only ever observed through a set valid bit, so they can map to plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_alloc)  tag_mem[upd_idx]    <= upd_tag;
    if (wr_target) target_mem[upd_idx] <= upd_target_i;
    if (wr_ctr)    ctr_mem[upd_idx]    <= ctr_new;
  end

  // Update PC bits outside index and tag carry no information for training.
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc_i[1:0], upd_pc_i[ADDR_W-1:IDX_W+2+TAG_W]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Scoreboard bench for branch_predictor. The driver computes the expected
// registered prediction and ready flag from a behavioural model of the BTB and
// queues them; a monitor pops and compares after every clock edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         fetch_valid_i = 1'b0;
  logic         stall_i = 1'b0;
  addr_pc_t     pc_fetch_i = '0;
  logic         upd_valid_i = 1'b0;
  addr_pc_t     upd_pc_i = '0;
  logic         upd_taken_i = 1'b0;
  addr_pc_t     upd_target_i = '0;
  branch_pred_t bpred_o;
  logic         ready_o;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_valid_i (fetch_valid_i),
    .stall_i       (stall_i),
    .pc_fetch_i    (pc_fetch_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .bpred_o       (bpred_o),
    .ready_o       (ready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a table of entries addressed with plain arithmetic.
  // ---------------------------------------------------------------------------
  bit       m_valid  [ENTRIES];
  int       m_tag    [ENTRIES];
  addr_pc_t m_target [ENTRIES];
  int       m_ctr    [ENTRIES];
  int       m_init_left = ENTRIES;
  branch_pred_t m_last = '0;

  function automatic int pc_index(addr_pc_t pc);
    longint unsigned p;
    p = 64'(pc);
    return int'((p / 4) % ENTRIES);
  endfunction

  function automatic int pc_tag(addr_pc_t pc);
    longint unsigned p;
    p = 64'(pc);
    return int'((p / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  function automatic branch_pred_t model_lookup(addr_pc_t pc, bit rdy);
    branch_pred_t r;
    int  idx;
    bit  hit;
    idx = pc_index(pc);
    hit = rdy && m_valid[idx] && (m_tag[idx] == pc_tag(pc));
    r = '0;
    r.is_branch = hit;
    r.decision  = (hit && m_ctr[idx] >= 2) ? TAKEN : NOT_TAKEN;
    r.pred_addr = hit ? m_target[idx] : addr_pc_t'(pc + 40'd4);
    return r;
  endfunction

  task automatic model_update(addr_pc_t pc, bit taken, addr_pc_t tgt);
    int idx;
    idx = pc_index(pc);
    if (m_valid[idx] && m_tag[idx] == pc_tag(pc)) begin
      if (taken) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = pc_tag(pc);
      m_target[idx] = tgt;
      m_ctr[idx]    = 2;
    end
  endtask

  typedef struct {
    branch_pred_t bpred;
    logic         ready;
  } exp_t;

  exp_t exp_q[$];

  // One clock of stimulus: drive on the falling edge, predict the state the DUT
  // shows after the following rising edge, queue it, then wait for that edge.
  task automatic cycle(input logic r, input logic fv, input logic st, input addr_pc_t pc,
                       input logic uv, input addr_pc_t upc, input logic ut, input addr_pc_t utgt);
    exp_t e;
    bit   rdy_before;
    @(negedge clk_i);
    rst_i         = r;
    fetch_valid_i = fv;
    stall_i       = st;
    pc_fetch_i    = pc;
    upd_valid_i   = uv;
    upd_pc_i      = upc;
    upd_taken_i   = ut;
    upd_target_i  = utgt;
    rdy_before = (m_init_left == 0);
    if (r) begin
      m_last      = '0;
      m_init_left = ENTRIES;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      if (!st) m_last = fv ? model_lookup(pc, rdy_before) : '0;
      if (rdy_before && uv) model_update(upc, ut, utgt);
      if (m_init_left > 0) m_init_left--;
    end
    e.bpred = m_last;
    e.ready = (m_init_left == 0);
    exp_q.push_back(e);
    @(posedge clk_i);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic lookup(input addr_pc_t pc);
    cycle(1'b0, 1'b1, 1'b0, pc, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic train(input addr_pc_t pc, input logic taken, input addr_pc_t tgt);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, pc, taken, tgt);
  endtask

  // Count clocks after a reset until ready_o rises, looking up pc each cycle.
  task automatic count_to_ready(input string name, input addr_pc_t pc);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      lookup(pc);
      n++;
      #2;
      if (ready_o === 1'b1) break;
    end
    check(name, 64'(n), 64'(ENTRIES));
  endtask

  // Random PCs drawn from a few indices/tags so hits, aliasing and the
  // all-ones wrap case all occur.
  function automatic addr_pc_t rand_pc();
    int idx_pool[4] = '{0, 1, 5, ENTRIES - 1};
    int tag_pool[3] = '{0, 1, (1 << TAG_W) - 1};
    addr_pc_t hi, pc;
    hi = ($urandom_range(1, 0) == 0) ? addr_pc_t'(0) : addr_pc_t'(24'hFF_FFFF);
    pc = (hi << 16)
       | (addr_pc_t'(tag_pool[$urandom_range(2, 0)]) << 8)
       | (addr_pc_t'(idx_pool[$urandom_range(3, 0)]) << 2)
       | addr_pc_t'($urandom_range(3, 0));
    return pc;
  endfunction

  function automatic addr_pc_t rand_addr();
    return addr_pc_t'({$urandom, $urandom});
  endfunction

  // Monitor: the DUT presents a new prediction after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bpred", 64'(bpred_o), 64'(e.bpred));
        check("ready", 64'(ready_o), 64'(e.ready));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  localparam addr_pc_t PC_A     = 40'h00_0000_1000;
  localparam addr_pc_t PC_ALIAS = 40'h00_0000_1100;  // same index as PC_A, tag + 1
  localparam addr_pc_t PC_ONES  = 40'hFF_FFFF_FFFF;

  initial begin
    // Reset and init walk.
    do_reset();
    count_to_ready("ready_latency", PC_A);

    // Allocate and hit.
    train(PC_A, 1'b1, 40'h2000);
    lookup(PC_A);

    // Counter down to 0 with one extra not-taken, then up to 3.
    repeat (3) train(PC_A, 1'b0, 40'h9999);
    lookup(PC_A);
    repeat (4) train(PC_A, 1'b1, 40'h2000);
    lookup(PC_A);

    // Aliasing: same index, different tag evicts PC_A.
    train(PC_ALIAS, 1'b1, 40'h5000);
    lookup(PC_A);
    lookup(PC_ALIAS);

    // Re-allocate PC_A, then lookup and update in the same cycle.
    train(PC_A, 1'b1, 40'h2000);
    cycle(1'b0, 1'b1, 1'b0, PC_A, 1'b1, PC_A, 1'b1, 40'h3000);
    lookup(PC_A);

    // Stall holds the hit while the fetch PC keeps changing.
    lookup(PC_A);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b1, rand_pc(), 1'b0, '0, 1'b0, '0);
    idle();

    // All-ones PC: miss wraps to 3, then hits after allocation.
    lookup(PC_ONES);
    train(PC_ONES, 1'b1, 40'h12_3456_789C);
    lookup(PC_ONES);

    // Reset mid-init restarts the walk; lookups of a previously trained PC miss.
    do_reset();
    repeat (30) lookup(PC_A);
    do_reset();
    count_to_ready("ready_after_restart", PC_A);
    lookup(PC_A);

    // Randomised traffic, including occasional resets and updates during init.
    for (int i = 0; i < 1500; i++) begin
      addr_pc_t pc;
      pc = rand_pc();
      cycle(($urandom_range(299, 0) == 0),
            ($urandom_range(9, 0) < 8),
            ($urandom_range(9, 0) < 2),
            rand_pc(),
            ($urandom_range(9, 0) < 4),
            pc,
            ($urandom_range(9, 0) < 6),
            rand_addr());
    end

    idle();
    repeat (2) @(posedge clk_i);
    #2;
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
